beta_mem_stage: RTL and testbench
=================================

# beta_mem_stage

Memory-access stage that sits directly downstream of the execute stage. It accepts one instruction per handshake, issues load and store requests on the data-memory valid/ready protocol, aligns and extends load data, and hands a result to write-back. Non-memory instructions pass through with one cycle of latency. The execute stage stalls on `in_rdy`.

## Interface
- `DATA_W`, default 32: data and address width. Only 32 is supported.
- `clk` input 1: clock.
- `rst_n` input 1: reset. Asynchronous, active-low.
- `in_vld` / `in_rdy`: input 1 / output 1. Handshake with the execute stage.
- `in_mem_op_en`, `in_mem_op`, `in_mem_op_size[1:0]`: input. Memory request, load(0)/store(1), and size.
- `in_unsigned_n`: input 1. Sign-extend loads when 1.
- `in_reg_wr_en` input 1, `in_rd` input 5: destination register control.
- `in_res` input 32: ALU result. Used as the memory address when `in_mem_op_en`=1.
- `in_wdata` input 32: store data (rs2).
- `dmem_rd_req_vld` output 1, `dmem_rd_req_rdy` input 1, `dmem_rd_rsp_vld` input 1, `dmem_rd_rsp_data` input 32: load channel.
- `dmem_wr_req_vld` output 1, `dmem_wr_req_rdy` input 1, `dmem_wr_rsp_vld` input 1: store channel.
- `dmem_addr` output 32, `dmem_wr_data` output 32, `dmem_wr_be` output 4: request payload, held stable while the request valid is high.
- `wb_vld` output 1, `wb_reg_wr_en` output 1, `wb_rd` output 5, `wb_data` output 32: result to write-back, a single-cycle pulse.
- `trap_vld` output 1, `trap_cause` output 5, `trap_tval` output 32: misalignment trap (see Configuration).

## Operation
- Two FSMs, each using the states IDLE(00), WRDY(01), WVLD(10):
  - read FSM (RDMEM) for loads;
  - write FSM (WDMEM) for stores.
- `in_rdy` = both FSMs in IDLE and `rst_n` deasserted. At most one access is outstanding.
- On accept with `in_mem_op_en`=0:
  - register `wb_*`; `wb_data` = `in_res`;
  - `wb_vld`=1 on the next cycle.
- On accept with `in_mem_op_en`=1, register address, data, size, sign and rd, then move to WRDY.
  - In WRDY: the matching `*_req_vld`=1. When `*_req_rdy`=1, go to WVLD and drop the valid on the next cycle.
  - In WVLD: on `*_rsp_vld`=1, go to IDLE and pulse `wb_vld` on the next cycle.
  - Responses while IDLE or WRDY are ignored.
- Size encoding: 01 word, 10 half, 11 byte. Size 00 with `mem_op_en` is treated as word.
- Byte enables:
  - byte: `4'b0001<<addr[1:0]`;
  - half: `4'b0011<<{addr[1],1'b0}`;
  - word: `4'b1111`.
- `dmem_wr_data`:
  - byte: `{4{wdata[7:0]}}`;
  - half: `{2{wdata[15:0]}}`;
  - word: `wdata`.
- Load data: select the lane with `addr[1:0]`, then sign-extend or zero-extend to 32 bits per `in_unsigned_n`.
- For stores, `wb_reg_wr_en`=0 regardless of the input.
- `dmem_addr` keeps its low bits. Memory uses `be` for lane selection.

## Timing
- Reset value of every output is 0, except `in_rdy`=1 once reset is released.
- Non-memory latency: accept at cycle N, `wb_vld` at N+1. Back-to-back throughput is 1 per cycle.
- Load/store minimum latency, with `rdy` and `rsp` immediate:
  - accept at N;
  - `req_vld` at N+1;
  - WVLD at N+2, with `rsp` sampled at N+2;
  - `wb_vld` at N+3.
  - Throughput is one access per 3 cycles.
- Once raised, `req_vld` stays high with a stable payload until `rdy`. Response data is sampled only on the `rsp_vld` cycle.
- Reset asserted mid-access: both FSMs return to IDLE asynchronously and all valids drop. Any late response is ignored.

## Configuration
- `BETA_LSU_MISALIGN_TRAP_EN` defined: misalignment is word with `addr[1:0]`≠0, or half with `addr[0]`=1. On a misaligned accept:
  - no dmem request is issued;
  - `trap_vld` pulses at N+1 with `trap_cause` 4 (load) or 6 (store) and `trap_tval` = address;
  - `wb_vld` stays 0.
- Undefined: the misaligned address is force-aligned (low bits cleared per size) and the access proceeds normally. `trap_*` outputs are tied to 0.

## Structure
- Shared package `beta_mem_stage_pkg`:
  - `mem_ctrl_t` (registered request fields);
  - RDMEM_*/WDMEM_* state constants and MEM_SIZE_* encodings, reused from the execute package;
  - trap cause constants `CAUSE_LD_MISALIGN`=4 and `CAUSE_ST_MISALIGN`=6.
- Sub-module `beta_mem_align`: combinational byte-enable and store-replication generation plus load lane-select and extension.

## Test plan
- ALU op, `in_res`=0x1234, `rd`=5 -> `wb_vld` at N+1, `wb_data`=0x1234, `wb_rd`=5.
- Load byte signed, addr 0x103, `rsp_data`=0x80FF_FF00 -> `wb_data`=0xFFFF_FF80; `rdy` delayed 3 cycles -> `req_vld` held with `addr` stable.
- Store half, addr 0x202, `wdata`=0xABCD -> `be`=1100, `wr_data`=0xABCD_ABCD, `wb_reg_wr_en`=0 after `wr_rsp_vld`.
- Load half unsigned, addr 0x2, data 0x8001_0000 -> `wb_data`=0x0000_8001; `in_rdy`=0 throughout the access.
- Misaligned word load, addr 0x6:
  - macro defined -> `trap_vld`, `cause`=4, `tval`=0x6, no request;
  - undefined -> `dmem_addr`=0x4.
- Reset asserted while in WVLD -> all valids 0 immediately; a later `rsp_vld` produces no `wb_vld`.

Source files
------------

// File: rtl/beta_mem_stage_pkg.sv
// Shared types and constants for the beta memory-access stage.
package beta_mem_stage_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned BE_W    = 4;
    localparam int unsigned RD_W    = 5;
    localparam int unsigned CAUSE_W = 5;

    typedef enum logic [1:0] {
        RDMEM_IDLE = 2'b00,
        RDMEM_WRDY = 2'b01,
        RDMEM_WVLD = 2'b10
    } rdmem_state_t;

    typedef enum logic [1:0] {
        WDMEM_IDLE = 2'b00,
        WDMEM_WRDY = 2'b01,
        WDMEM_WVLD = 2'b10
    } wdmem_state_t;

    localparam logic [1:0] MEM_SIZE_WORD = 2'b01;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b10;
    localparam logic [1:0] MEM_SIZE_BYTE = 2'b11;

    localparam logic [CAUSE_W-1:0] CAUSE_LD_MISALIGN = CAUSE_W'(4);
    localparam logic [CAUSE_W-1:0] CAUSE_ST_MISALIGN = CAUSE_W'(6);

    // Request fields captured at accept and held for the whole access.
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [BE_W-1:0] be;
        logic [1:0]      size;
        logic            unsigned_n;
        logic            reg_wr_en;
        logic [RD_W-1:0] rd;
    } mem_ctrl_t;

    // Size 00 behaves as word, so only half and byte relax the check.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
        case (size)
            MEM_SIZE_HALF: return addr_lo[0];
            MEM_SIZE_BYTE: return 1'b0;
            default:       return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/beta_mem_align.sv
// Store byte-enable/replication and load lane-select/extension (combinational).
module beta_mem_align
    import beta_mem_stage_pkg::*;
(
    input  logic [XLEN-1:0] req_addr,
    input  logic [1:0]      req_size,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [1:0]      ld_addr_lo,
    input  logic [1:0]      ld_size,
    input  logic            ld_unsigned_n,
    input  logic [XLEN-1:0] ld_rdata,
    output logic [XLEN-1:0] addr_c,
    output logic [BE_W-1:0] be_c,
    output logic [XLEN-1:0] wr_data_c,
    output logic [XLEN-1:0] ld_data_c
);

    logic [XLEN-1:0] ld_shift;

    // Low address bits are cleared per size; aligned requests pass unchanged.
    always_comb begin
        addr_c    = {req_addr[XLEN-1:2], 2'b00};
        be_c      = 4'b1111;
        wr_data_c = req_wdata;
        case (req_size)
            MEM_SIZE_BYTE: begin
                addr_c    = req_addr;
                be_c      = 4'b0001 << req_addr[1:0];
                wr_data_c = {4{req_wdata[7:0]}};
            end
            MEM_SIZE_HALF: begin
                addr_c    = {req_addr[XLEN-1:1], 1'b0};
                be_c      = 4'b0011 << {req_addr[1], 1'b0};
                wr_data_c = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign ld_shift = ld_rdata >> {ld_addr_lo, 3'b000};

    always_comb begin
        ld_data_c = ld_rdata;
        case (ld_size)
            MEM_SIZE_BYTE: ld_data_c = {{24{ld_unsigned_n & ld_shift[7]}}, ld_shift[7:0]};
            MEM_SIZE_HALF: ld_data_c = {{16{ld_unsigned_n & ld_shift[15]}}, ld_shift[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/beta_mem_stage.sv
// Memory-access stage: load/store FSMs on the dmem valid/ready channels.
// Define BETA_LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning.
module beta_mem_stage
    import beta_mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_vld,
    output logic                in_rdy,
    input  logic                in_mem_op_en,
    input  logic                in_mem_op,
    input  logic [1:0]          in_mem_op_size,
    input  logic                in_unsigned_n,
    input  logic                in_reg_wr_en,
    input  logic [RD_W-1:0]     in_rd,
    input  logic [DATA_W-1:0]   in_res,
    input  logic [DATA_W-1:0]   in_wdata,
    output logic                dmem_rd_req_vld,
    input  logic                dmem_rd_req_rdy,
    input  logic                dmem_rd_rsp_vld,
    input  logic [DATA_W-1:0]   dmem_rd_rsp_data,
    output logic                dmem_wr_req_vld,
    input  logic                dmem_wr_req_rdy,
    input  logic                dmem_wr_rsp_vld,
    output logic [DATA_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0]   dmem_wr_data,
    output logic [BE_W-1:0]     dmem_wr_be,
    output logic                wb_vld,
    output logic                wb_reg_wr_en,
    output logic [RD_W-1:0]     wb_rd,
    output logic [DATA_W-1:0]   wb_data,
    output logic                trap_vld,
    output logic [CAUSE_W-1:0]  trap_cause,
    output logic [DATA_W-1:0]   trap_tval
);

    rdmem_state_t      rd_state, rd_state_nxt;
    wdmem_state_t      wr_state, wr_state_nxt;
    mem_ctrl_t         ctrl, ctrl_nxt;
    logic              wb_vld_nxt, wb_reg_wr_en_nxt;
    logic [RD_W-1:0]   wb_rd_nxt;
    logic [DATA_W-1:0] wb_data_nxt;
    logic              accept;
    logic [XLEN-1:0]   al_addr, al_wr_data, ld_data;
    logic [BE_W-1:0]   al_be;

    beta_mem_align u_align (
        .req_addr      (in_res),
        .req_size      (in_mem_op_size),
        .req_wdata     (in_wdata),
        .ld_addr_lo    (ctrl.addr[1:0]),
        .ld_size       (ctrl.size),
        .ld_unsigned_n (ctrl.unsigned_n),
        .ld_rdata      (dmem_rd_rsp_data),
        .addr_c        (al_addr),
        .be_c          (al_be),
        .wr_data_c     (al_wr_data),
        .ld_data_c     (ld_data)
    );

    assign in_rdy          = rst_n && (rd_state == RDMEM_IDLE) && (wr_state == WDMEM_IDLE);
    assign accept          = in_vld && in_rdy;
    assign dmem_rd_req_vld = (rd_state == RDMEM_WRDY);
    assign dmem_wr_req_vld = (wr_state == WDMEM_WRDY);
    assign dmem_addr       = ctrl.addr;
    assign dmem_wr_data    = ctrl.wdata;
    assign dmem_wr_be      = ctrl.be;

`ifdef BETA_LSU_MISALIGN_TRAP_EN
    logic               trap_vld_nxt;
    logic [CAUSE_W-1:0] trap_cause_nxt;
    logic [DATA_W-1:0]  trap_tval_nxt;
`endif

    always_comb begin
        rd_state_nxt     = rd_state;
        wr_state_nxt     = wr_state;
        ctrl_nxt         = ctrl;
        wb_vld_nxt       = 1'b0;
        wb_reg_wr_en_nxt = wb_reg_wr_en;
        wb_rd_nxt        = wb_rd;
        wb_data_nxt      = wb_data;
`ifdef BETA_LSU_MISALIGN_TRAP_EN
        trap_vld_nxt     = 1'b0;
        trap_cause_nxt   = trap_cause;
        trap_tval_nxt    = trap_tval;
`endif

        if (accept) begin
            if (!in_mem_op_en) begin
                wb_vld_nxt       = 1'b1;
                wb_reg_wr_en_nxt = in_reg_wr_en;
                wb_rd_nxt        = in_rd;
                wb_data_nxt      = in_res;
            end
`ifdef BETA_LSU_MISALIGN_TRAP_EN
            else if (is_misaligned(in_res[1:0], in_mem_op_size)) begin
                trap_vld_nxt   = 1'b1;
                trap_cause_nxt = in_mem_op ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
                trap_tval_nxt  = in_res;
            end
`endif
            else begin
                ctrl_nxt.addr       = al_addr;
                ctrl_nxt.wdata      = al_wr_data;
                ctrl_nxt.be         = al_be;
                ctrl_nxt.size       = in_mem_op_size;
                ctrl_nxt.unsigned_n = in_unsigned_n;
                ctrl_nxt.reg_wr_en  = in_reg_wr_en && !in_mem_op;
                ctrl_nxt.rd         = in_rd;
                if (in_mem_op) wr_state_nxt = WDMEM_WRDY;
                else           rd_state_nxt = RDMEM_WRDY;
            end
        end

        // Load channel
        case (rd_state)
            RDMEM_WRDY: if (dmem_rd_req_rdy) rd_state_nxt = RDMEM_WVLD;
            RDMEM_WVLD: if (dmem_rd_rsp_vld) begin
                rd_state_nxt     = RDMEM_IDLE;
                wb_vld_nxt       = 1'b1;
                wb_reg_wr_en_nxt = ctrl.reg_wr_en;
                wb_rd_nxt        = ctrl.rd;
                wb_data_nxt      = ld_data;
            end
            default: ;
        endcase

        // Store channel
        case (wr_state)
            WDMEM_WRDY: if (dmem_wr_req_rdy) wr_state_nxt = WDMEM_WVLD;
            WDMEM_WVLD: if (dmem_wr_rsp_vld) begin
                wr_state_nxt     = WDMEM_IDLE;
                wb_vld_nxt       = 1'b1;
                wb_reg_wr_en_nxt = 1'b0;
                wb_rd_nxt        = ctrl.rd;
                wb_data_nxt      = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state     <= RDMEM_IDLE;
            wr_state     <= WDMEM_IDLE;
            ctrl         <= '0;
            wb_vld       <= 1'b0;
            wb_reg_wr_en <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
        end else begin
            rd_state     <= rd_state_nxt;
            wr_state     <= wr_state_nxt;
            ctrl         <= ctrl_nxt;
            wb_vld       <= wb_vld_nxt;
            wb_reg_wr_en <= wb_reg_wr_en_nxt;
            wb_rd        <= wb_rd_nxt;
            wb_data      <= wb_data_nxt;
        end
    end

`ifdef BETA_LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_vld   <= 1'b0;
            trap_cause <= '0;
            trap_tval  <= '0;
        end else begin
            trap_vld   <= trap_vld_nxt;
            trap_cause <= trap_cause_nxt;
            trap_tval  <= trap_tval_nxt;
        end
    end
`else
    assign trap_vld   = 1'b0;
    assign trap_cause = '0;
    assign trap_tval  = '0;
`endif

endmodule

// File: tb/tb_beta_mem_stage.sv
// Self-checking bench for beta_mem_stage: vector table plus write-back scoreboard.
module tb_beta_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_vld, in_rdy, in_mem_op_en, in_mem_op, in_unsigned_n, in_reg_wr_en;
    logic [1:0]  in_mem_op_size;
    logic [4:0]  in_rd;
    logic [31:0] in_res, in_wdata;
    logic        dmem_rd_req_vld, dmem_rd_req_rdy, dmem_rd_rsp_vld;
    logic [31:0] dmem_rd_rsp_data;
    logic        dmem_wr_req_vld, dmem_wr_req_rdy, dmem_wr_rsp_vld;
    logic [31:0] dmem_addr, dmem_wr_data;
    logic [3:0]  dmem_wr_be;
    logic        wb_vld, wb_reg_wr_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        trap_vld;
    logic [4:0]  trap_cause;
    logic [31:0] trap_tval;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        mem_en;
        logic        op;
        logic [1:0]  size;
        logic        uns_n;
        logic        wr_en;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [31:0] wdata;
        logic [31:0] rsp;
        int          dly;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wr_data;
        logic [31:0] exp_wb;
        logic        exp_wb_en;
        logic        chk_data;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        wr_en;
        logic        chk_data;
    } sb_t;

    sb_t  sb[$];
    vec_t vecs[11];

    always #5 clk = ~clk;

    beta_mem_stage #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld), .in_rdy(in_rdy),
        .in_mem_op_en(in_mem_op_en), .in_mem_op(in_mem_op), .in_mem_op_size(in_mem_op_size),
        .in_unsigned_n(in_unsigned_n), .in_reg_wr_en(in_reg_wr_en), .in_rd(in_rd),
        .in_res(in_res), .in_wdata(in_wdata),
        .dmem_rd_req_vld(dmem_rd_req_vld), .dmem_rd_req_rdy(dmem_rd_req_rdy),
        .dmem_rd_rsp_vld(dmem_rd_rsp_vld), .dmem_rd_rsp_data(dmem_rd_rsp_data),
        .dmem_wr_req_vld(dmem_wr_req_vld), .dmem_wr_req_rdy(dmem_wr_req_rdy),
        .dmem_wr_rsp_vld(dmem_wr_rsp_vld),
        .dmem_addr(dmem_addr), .dmem_wr_data(dmem_wr_data), .dmem_wr_be(dmem_wr_be),
        .wb_vld(wb_vld), .wb_reg_wr_en(wb_reg_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .trap_vld(trap_vld), .trap_cause(trap_cause), .trap_tval(trap_tval)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (!in_rdy && n < 20) begin
            step();
            n++;
        end
        chk("in_rdy_wait", 32'(in_rdy), 32'd1);
    endtask

    task automatic drive(input vec_t v);
        in_mem_op_en   = v.mem_en;
        in_mem_op      = v.op;
        in_mem_op_size = v.size;
        in_unsigned_n  = v.uns_n;
        in_reg_wr_en   = v.wr_en;
        in_rd          = v.rd;
        in_res         = v.res;
        in_wdata       = v.wdata;
    endtask

    function automatic sb_t exp_of(input vec_t v);
        sb_t e;
        e.rd       = v.rd;
        e.data     = v.exp_wb;
        e.wr_en    = v.exp_wb_en;
        e.chk_data = v.chk_data;
        return e;
    endfunction

    // Scoreboard: every write-back pulse must match the oldest expectation.
    always @(negedge clk) begin
        sb_t e;
        if (rst_n && wb_vld) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", 32'(wb_vld), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_reg_wr_en", 32'(wb_reg_wr_en), 32'(e.wr_en));
                if (e.chk_data) chk("wb_data", wb_data, e.data);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        logic [31:0] addr0;
        wait_rdy();
        drive(v);
        in_vld = 1'b1;
        sb.push_back(exp_of(v));
        step();
        in_vld = 1'b0;
        if (!v.mem_en) begin
            chk("alu_wb_vld_n1", 32'(wb_vld), 32'd1);
        end else begin
            chk("req_vld", 32'(v.op ? dmem_wr_req_vld : dmem_rd_req_vld), 32'd1);
            chk("other_req_vld", 32'(v.op ? dmem_rd_req_vld : dmem_wr_req_vld), 32'd0);
            chk("dmem_addr", dmem_addr, v.exp_addr);
            if (v.op) begin
                chk("dmem_wr_be", 32'(dmem_wr_be), 32'(v.exp_be));
                chk("dmem_wr_data", dmem_wr_data, v.exp_wr_data);
            end
            addr0 = dmem_addr;
            for (int i = 0; i < v.dly; i++) begin
                step();
                chk("req_vld_hold", 32'(v.op ? dmem_wr_req_vld : dmem_rd_req_vld), 32'd1);
                chk("addr_stable", dmem_addr, addr0);
                chk("in_rdy_busy", 32'(in_rdy), 32'd0);
            end
            if (v.op) dmem_wr_req_rdy = 1'b1; else dmem_rd_req_rdy = 1'b1;
            step();
            dmem_wr_req_rdy = 1'b0;
            dmem_rd_req_rdy = 1'b0;
            chk("req_vld_drop", 32'(v.op ? dmem_wr_req_vld : dmem_rd_req_vld), 32'd0);
            chk("wb_vld_early", 32'(wb_vld), 32'd0);
            chk("in_rdy_wvld", 32'(in_rdy), 32'd0);
            if (v.op) dmem_wr_rsp_vld = 1'b1;
            else begin
                dmem_rd_rsp_vld  = 1'b1;
                dmem_rd_rsp_data = v.rsp;
            end
            step();
            dmem_wr_rsp_vld  = 1'b0;
            dmem_rd_rsp_vld  = 1'b0;
            dmem_rd_rsp_data = 32'h0;
            chk("mem_wb_vld_n3", 32'(wb_vld), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //          en   op   sz     un   we   rd     res            wdata          rsp            dly addr           be       wr_data        wb             wben chk
        vecs[0]  = '{1'b0,1'b0,2'b00,1'b1,1'b1,5'd5, 32'h0000_1234,32'h0,         32'h0,         0, 32'h0,         4'b0000, 32'h0,         32'h0000_1234,1'b1,1'b1};
        vecs[1]  = '{1'b0,1'b0,2'b00,1'b1,1'b0,5'd31,32'hDEAD_BEEF,32'h0,         32'h0,         0, 32'h0,         4'b0000, 32'h0,         32'hDEAD_BEEF,1'b0,1'b1};
        vecs[2]  = '{1'b1,1'b0,2'b11,1'b1,1'b1,5'd7, 32'h0000_0103,32'h0,         32'h80FF_FF00, 3, 32'h0000_0103,4'b1000, 32'h0,         32'hFFFF_FF80,1'b1,1'b1};
        vecs[3]  = '{1'b1,1'b1,2'b10,1'b1,1'b1,5'd9, 32'h0000_0202,32'h0000_ABCD,32'h0,         0, 32'h0000_0202,4'b1100, 32'hABCD_ABCD,32'h0,        1'b0,1'b0};
        vecs[4]  = '{1'b1,1'b0,2'b10,1'b0,1'b1,5'd10,32'h0000_0002,32'h0,         32'h8001_0000, 1, 32'h0000_0002,4'b1100, 32'h0,         32'h0000_8001,1'b1,1'b1};
        vecs[5]  = '{1'b1,1'b0,2'b01,1'b1,1'b1,5'd11,32'h0000_0040,32'h0,         32'h1234_5678, 0, 32'h0000_0040,4'b1111, 32'h0,         32'h1234_5678,1'b1,1'b1};
        vecs[6]  = '{1'b1,1'b0,2'b11,1'b0,1'b1,5'd12,32'h0000_0101,32'h0,         32'h0000_C300, 0, 32'h0000_0101,4'b0010, 32'h0,         32'h0000_00C3,1'b1,1'b1};
        vecs[7]  = '{1'b1,1'b1,2'b11,1'b1,1'b1,5'd13,32'h0000_0011,32'h1234_565A,32'h0,         2, 32'h0000_0011,4'b0010, 32'h5A5A_5A5A,32'h0,        1'b0,1'b0};
        vecs[8]  = '{1'b1,1'b1,2'b01,1'b1,1'b1,5'd14,32'h0000_0020,32'hCAFE_F00D,32'h0,         0, 32'h0000_0020,4'b1111, 32'hCAFE_F00D,32'h0,        1'b0,1'b0};
        vecs[9]  = '{1'b1,1'b0,2'b10,1'b1,1'b1,5'd15,32'h0000_0000,32'h0,         32'h1234_F00F, 0, 32'h0000_0000,4'b0011, 32'h0,         32'hFFFF_F00F,1'b1,1'b1};
        vecs[10] = '{1'b1,1'b0,2'b00,1'b1,1'b1,5'd16,32'h0000_0008,32'h0,         32'h1122_3344, 0, 32'h0000_0008,4'b1111, 32'h0,         32'h1122_3344,1'b1,1'b1};

        rst_n = 1'b0;
        in_vld = 1'b0; in_mem_op_en = 1'b0; in_mem_op = 1'b0; in_mem_op_size = 2'b00;
        in_unsigned_n = 1'b0; in_reg_wr_en = 1'b0; in_rd = 5'd0; in_res = 32'h0; in_wdata = 32'h0;
        dmem_rd_req_rdy = 1'b0; dmem_rd_rsp_vld = 1'b0; dmem_rd_rsp_data = 32'h0;
        dmem_wr_req_rdy = 1'b0; dmem_wr_rsp_vld = 1'b0;

        step();
        chk("rst_in_rdy", 32'(in_rdy), 32'd0);
        chk("rst_wb_vld", 32'(wb_vld), 32'd0);
        chk("rst_rd_req_vld", 32'(dmem_rd_req_vld), 32'd0);
        chk("rst_wr_req_vld", 32'(dmem_wr_req_vld), 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'h0);
        chk("rst_trap_vld", 32'(trap_vld), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_rdy", 32'(in_rdy), 32'd1);

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Back-to-back ALU ops: one accept and one write-back per cycle.
        wait_rdy();
        for (int i = 0; i < 4; i++) begin
            v = vecs[0];
            v.rd = 5'(20 + i);
            v.res = 32'hA000_0000 + 32'(i);
            v.exp_wb = v.res;
            drive(v);
            in_vld = 1'b1;
            sb.push_back(exp_of(v));
            step();
            chk("b2b_wb_vld", 32'(wb_vld), 32'd1);
            chk("b2b_in_rdy", 32'(in_rdy), 32'd1);
        end
        in_vld = 1'b0;
        step();
        chk("b2b_wb_vld_end", 32'(wb_vld), 32'd0);

        // Misaligned word load at 0x6.
        v = vecs[5];
        v.res = 32'h0000_0006;
`ifdef BETA_LSU_MISALIGN_TRAP_EN
        wait_rdy();
        drive(v);
        in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        chk("trap_vld", 32'(trap_vld), 32'd1);
        chk("trap_cause_ld", 32'(trap_cause), 32'd4);
        chk("trap_tval", trap_tval, 32'h0000_0006);
        chk("trap_no_req", 32'(dmem_rd_req_vld), 32'd0);
        chk("trap_no_wb", 32'(wb_vld), 32'd0);
        step();
        chk("trap_pulse", 32'(trap_vld), 32'd0);
        v = vecs[3];
        v.res = 32'h0000_0203;
        wait_rdy();
        drive(v);
        in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        chk("trap_cause_st", 32'(trap_cause), 32'd6);
        chk("trap_st_no_req", 32'(dmem_wr_req_vld), 32'd0);
`else
        v.exp_addr = 32'h0000_0004;
        v.rsp = 32'hAABB_CCDD;
        v.exp_wb = 32'hAABB_CCDD;
        run_vec(v);
        chk("no_trap", 32'(trap_vld), 32'd0);
`endif

        // Reset while waiting for a load response; the late response must be ignored.
        wait_rdy();
        v = vecs[5];
        v.res = 32'h0000_0030;
        drive(v);
        in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        dmem_rd_req_rdy = 1'b1;
        step();
        dmem_rd_req_rdy = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rd_req_vld", 32'(dmem_rd_req_vld), 32'd0);
        chk("rst_mid_wr_req_vld", 32'(dmem_wr_req_vld), 32'd0);
        chk("rst_mid_wb_vld", 32'(wb_vld), 32'd0);
        chk("rst_mid_in_rdy", 32'(in_rdy), 32'd0);
        step();
        rst_n = 1'b1;
        dmem_rd_rsp_vld = 1'b1;
        dmem_rd_rsp_data = 32'h5555_5555;
        step();
        dmem_rd_rsp_vld = 1'b0;
        chk("late_rsp_wb_vld", 32'(wb_vld), 32'd0);
        step();
        chk("late_rsp_wb_vld2", 32'(wb_vld), 32'd0);
        chk("late_rsp_in_rdy", 32'(in_rdy), 32'd1);

        step();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
